// File: rtl/alu_op_sequencer.sv
// Registered command/result wrapper around a combinational add/subtract ALU.
// Launches operands, waits a fixed settle time, captures the result and holds it for a consumer.
module alu_op_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_m,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_m,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_cout,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_cout,
  output logic [3:0]       res_flags,
  input  logic             clr_sticky,
  output logic             sticky_c,
  output logic             sticky_v,
  output logic [15:0]      op_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_m_q, alu_m_d;
  logic [WIDTH-1:0] res_s_q, res_s_d;
  logic             res_cout_q, res_cout_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic             sticky_c_q, sticky_c_d;
  logic             sticky_v_q, sticky_v_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             capture;

  assign capture = (state_q == ST_SETTLE) && (cnt_q == 4'd0);

  // Operand launch, settle countdown, result capture and consumer handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_m_d     = alu_m_q;
    res_s_d     = res_s_q;
    res_cout_d  = res_cout_q;
    res_flags_d = res_flags_q;
    op_count_d  = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d = cmd_a;
          alu_b_d = cmd_b;
          alu_m_d = cmd_m;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (capture) begin
          res_s_d     = alu_s;
          res_cout_d  = alu_cout;
          res_flags_d = {alu_n, alu_z, alu_c, alu_v};
          state_d     = ST_OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A clear that lands on a capture edge keeps only the freshly captured flag.
  always_comb begin
    sticky_c_d = sticky_c_q;
    sticky_v_d = sticky_v_q;
    if (clr_sticky) begin
      sticky_c_d = capture & alu_c;
      sticky_v_d = capture & alu_v;
    end else if (capture) begin
      sticky_c_d = sticky_c_q | alu_c;
      sticky_v_d = sticky_v_q | alu_v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_m_q     <= 1'b0;
      res_s_q     <= '0;
      res_cout_q  <= 1'b0;
      res_flags_q <= 4'd0;
      sticky_c_q  <= 1'b0;
      sticky_v_q  <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_m_q     <= alu_m_d;
      res_s_q     <= res_s_d;
      res_cout_q  <= res_cout_d;
      res_flags_q <= res_flags_d;
      sticky_c_q  <= sticky_c_d;
      sticky_v_q  <= sticky_v_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_OUT);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_m     = alu_m_q;
  assign res_s     = res_s_q;
  assign res_cout  = res_cout_q;
  assign res_flags = res_flags_q;
  assign sticky_c  = sticky_c_q;
  assign sticky_v  = sticky_v_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with a 1-edge settle, one with a 4-edge settle,
// each closed around a behavioural 16-bit add/subtract ALU.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;

  // Instance with SETTLE_CYCLES=1
  logic        cmdValid, cmdReady, cmdM, aluM, resValid, resReady, resCout, clrSticky;
  logic        stickyC, stickyV, aluCout, aluN, aluZ, aluC, aluV;
  logic [15:0] cmdA, cmdB, aluA, aluB, aluS, resS, opCount;
  logic [3:0]  resFlags;

  // Instance with SETTLE_CYCLES=4
  logic        cmdValid4, cmdReady4, cmdM4, aluM4, resValid4, resReady4, resCout4;
  logic        stickyC4, stickyV4, aluCout4, aluN4, aluZ4, aluC4, aluV4;
  logic [15:0] cmdA4, cmdB4, aluA4, aluB4, aluS4, resS4, opCount4;
  logic [3:0]  resFlags4;

  int errors = 0;
  int checks = 0;

  // Behavioural ALU: S = A + (M ? ~B : B) + M, C = carry out, V = signed overflow.
  logic [15:0] bEff, bEff4;
  logic [16:0] sum, sum4;
  assign bEff     = aluM ? ~aluB : aluB;
  assign sum      = {1'b0, aluA} + {1'b0, bEff} + 17'(aluM);
  assign aluS     = sum[15:0];
  assign aluCout  = sum[16];
  assign aluN     = sum[15];
  assign aluZ     = (sum[15:0] == 16'd0);
  assign aluC     = sum[16];
  assign aluV     = (aluA[15] == bEff[15]) && (sum[15] != aluA[15]);
  assign bEff4    = aluM4 ? ~aluB4 : aluB4;
  assign sum4     = {1'b0, aluA4} + {1'b0, bEff4} + 17'(aluM4);
  assign aluS4    = sum4[15:0];
  assign aluCout4 = sum4[16];
  assign aluN4    = sum4[15];
  assign aluZ4    = (sum4[15:0] == 16'd0);
  assign aluC4    = sum4[16];
  assign aluV4    = (aluA4[15] == bEff4[15]) && (sum4[15] != aluA4[15]);

  alu_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_a(cmdA), .cmd_b(cmdB), .cmd_m(cmdM),
    .alu_a(aluA), .alu_b(aluB), .alu_m(aluM),
    .alu_s(aluS), .alu_cout(aluCout), .alu_n(aluN), .alu_z(aluZ), .alu_c(aluC), .alu_v(aluV),
    .res_valid(resValid), .res_ready(resReady), .res_s(resS), .res_cout(resCout),
    .res_flags(resFlags), .clr_sticky(clrSticky), .sticky_c(stickyC), .sticky_v(stickyV),
    .op_count(opCount)
  );

  alu_op_sequencer #(.WIDTH(16), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmdValid4), .cmd_ready(cmdReady4), .cmd_a(cmdA4), .cmd_b(cmdB4), .cmd_m(cmdM4),
    .alu_a(aluA4), .alu_b(aluB4), .alu_m(aluM4),
    .alu_s(aluS4), .alu_cout(aluCout4), .alu_n(aluN4), .alu_z(aluZ4), .alu_c(aluC4), .alu_v(aluV4),
    .res_valid(resValid4), .res_ready(resReady4), .res_s(resS4), .res_cout(resCout4),
    .res_flags(resFlags4), .clr_sticky(1'b0), .sticky_c(stickyC4), .sticky_v(stickyV4),
    .op_count(opCount4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one command to dut1 for exactly one edge, then wait (bounded) for its result.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m);
    int n;
    @(negedge clk);
    cmdA = a; cmdB = b; cmdM = m; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    n = 0;
    while (!resValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resValid) begin
      errors++; checks++;
      $display("[TB] FAIL wait_res_valid: res_valid=%b required 1 within 20 cycles", resValid);
    end
  endtask

  task automatic consume();
    resReady = 1'b1;
    @(negedge clk);
    resReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({cmdReady, resValid, aluA, aluB, aluM, resS, resCout, resFlags, stickyC, stickyV, opCount}
        !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b a=%h b=%h s=%h flags=%b cnt=%h required ready=1 all else 0",
               cmdReady, resValid, aluA, aluB, resS, resFlags, opCount);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    @(negedge clk);
    cmdA = 16'h1234; cmdB = 16'h4321; cmdM = 1'b0; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    checks++;
    if (resValid !== 1'b0 || cmdReady !== 1'b0 || aluA !== 16'h1234 || aluB !== 16'h4321) begin
      errors++;
      $display("[TB] FAIL add_launch: valid=%b ready=%b alu_a=%h alu_b=%h required 0 0 1234 4321",
               resValid, cmdReady, aluA, aluB);
    end
    @(negedge clk);
    checks++;
    if (resValid !== 1'b1 || resS !== 16'h5555 || resFlags !== 4'b0000 || resCout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_result: valid=%b s=%h flags=%b cout=%b required 1 5555 0000 0",
               resValid, resS, resFlags, resCout);
    end
    consume();
    checks++;
    if (resValid !== 1'b0 || opCount !== 16'd1 || cmdReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_consume: valid=%b op_count=%h ready=%b required 0 0001 1",
               resValid, opCount, cmdReady);
    end
  endtask

  task automatic test_backpressure();
    issue(16'h1234, 16'h4321, 1'b1);
    checks++;
    if (resS !== 16'hCF13 || resFlags !== 4'b1000 || resCout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_result: s=%h flags=%b cout=%b required cf13 1000 0", resS, resFlags, resCout);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmdValid = 1'b1;
      cmdA = 16'hFFFF;
      checks++;
      if (resValid !== 1'b1 || cmdReady !== 1'b0 || resS !== 16'hCF13 || aluA !== 16'h1234) begin
        errors++;
        $display("[TB] FAIL backpressure_hold[%0d]: valid=%b ready=%b s=%h alu_a=%h required 1 0 cf13 1234",
                 i, resValid, cmdReady, resS, aluA);
      end
    end
    cmdValid = 1'b0;
    consume();
    checks++;
    if (opCount !== 16'd2 || resS !== 16'hCF13) begin
      errors++;
      $display("[TB] FAIL backpressure_consume: op_count=%h s=%h required 0002 cf13", opCount, resS);
    end
  endtask

  task automatic test_sticky();
    issue(16'h7FFF, 16'h0001, 1'b0);
    checks++;
    if (resS !== 16'h8000 || resFlags !== 4'b1001 || stickyV !== 1'b1 || stickyC !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_op: s=%h flags=%b sv=%b sc=%b required 8000 1001 1 0",
               resS, resFlags, stickyV, stickyC);
    end
    consume();
    issue(16'h0001, 16'h0001, 1'b1);
    checks++;
    if (resS !== 16'h0000 || resFlags !== 4'b0110 || resCout !== 1'b1 || stickyV !== 1'b1 || stickyC !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_op: s=%h flags=%b cout=%b sv=%b sc=%b required 0000 0110 1 1 1",
               resS, resFlags, resCout, stickyV, stickyC);
    end
    consume();
    clrSticky = 1'b1;
    @(negedge clk);
    clrSticky = 1'b0;
    checks++;
    if (stickyV !== 1'b0 || stickyC !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sticky_clear: sv=%b sc=%b required 0 0", stickyV, stickyC);
    end
  endtask

  task automatic test_reset_mid_settle();
    @(negedge clk);
    cmdA4 = 16'h0003; cmdB4 = 16'h0004; cmdM4 = 1'b0; cmdValid4 = 1'b1;
    @(negedge clk);
    cmdValid4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (cmdReady4 !== 1'b1 || resValid4 !== 1'b0 || aluA4 !== 16'd0 || aluB4 !== 16'd0 || resS4 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_settle: ready=%b valid=%b alu_a=%h alu_b=%h s=%h required 1 0 0 0 0",
               cmdReady4, resValid4, aluA4, aluB4, resS4);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (resValid4 !== 1'b0 || cmdReady4 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL no_partial_result[%0d]: valid=%b ready=%b required 0 1", i, resValid4, cmdReady4);
      end
    end
    cmdA4 = 16'h0100; cmdB4 = 16'h0023; cmdM4 = 1'b0; cmdValid4 = 1'b1;
    @(negedge clk);
    cmdValid4 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (resValid4 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL settle4_early[%0d]: valid=%b required 0", i, resValid4);
      end
    end
    @(negedge clk);
    checks++;
    if (resValid4 !== 1'b1 || resS4 !== 16'h0123 || resFlags4 !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL settle4_result: valid=%b s=%h flags=%b required 1 0123 0000", resValid4, resS4, resFlags4);
    end
    resReady4 = 1'b1;
    @(negedge clk);
    resReady4 = 1'b0;
    checks++;
    if (resValid4 !== 1'b0 || opCount4 !== 16'd1) begin
      errors++;
      $display("[TB] FAIL settle4_consume: valid=%b op_count=%h required 0 0001", resValid4, opCount4);
    end
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force dut1.op_count_q = 16'hFFFF;
    #1;
    release dut1.op_count_q;
    issue(16'h0002, 16'h0003, 1'b0);
    checks++;
    if (opCount !== 16'hFFFF || resS !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL count_preload: op_count=%h s=%h required ffff 0005", opCount, resS);
    end
    consume();
    checks++;
    if (opCount !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL count_wrap: op_count=%h required 0000", opCount);
    end
  endtask

  task automatic test_clear_on_capture();
    issue(16'h7FFF, 16'h0001, 1'b0);
    consume();
    // Accept edge, then clr_sticky held across the capture edge.
    @(negedge clk);
    cmdA = 16'h7FFF; cmdB = 16'h0001; cmdM = 1'b0; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    clrSticky = 1'b1;
    @(negedge clk);
    clrSticky = 1'b0;
    checks++;
    if (resValid !== 1'b1 || stickyV !== 1'b1 || stickyC !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_on_capture_v1: valid=%b sv=%b sc=%b required 1 1 0", resValid, stickyV, stickyC);
    end
    consume();
    @(negedge clk);
    cmdA = 16'h0001; cmdB = 16'h0001; cmdM = 1'b0; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    clrSticky = 1'b1;
    @(negedge clk);
    clrSticky = 1'b0;
    checks++;
    if (resValid !== 1'b1 || resS !== 16'h0002 || stickyV !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_on_capture_v0: valid=%b s=%h sv=%b required 1 0002 0", resValid, resS, stickyV);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int base;
    base = int'(opCount);
    @(negedge clk);
    cmdA = 16'h0010; cmdB = 16'h0020; cmdM = 1'b0; cmdValid = 1'b1; resReady = 1'b1;
    @(negedge clk);
    cmdA = 16'h0100; cmdB = 16'h0200;
    @(negedge clk);
    checks++;
    if (resValid !== 1'b1 || resS !== 16'h0030) begin
      errors++;
      $display("[TB] FAIL b2b_first: valid=%b s=%h required 1 0030", resValid, resS);
    end
    @(negedge clk);
    checks++;
    if (resValid !== 1'b0 || cmdReady !== 1'b1 || aluA !== 16'h0010 || resS !== 16'h0030
        || opCount !== 16'(base + 1)) begin
      errors++;
      $display("[TB] FAIL b2b_handshake_edge: valid=%b ready=%b alu_a=%h s=%h cnt=%h required 0 1 0010 0030 %h",
               resValid, cmdReady, aluA, resS, opCount, 16'(base + 1));
    end
    @(negedge clk);
    cmdValid = 1'b0;
    checks++;
    if (aluA !== 16'h0100 || cmdReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second_accept: alu_a=%h ready=%b required 0100 0", aluA, cmdReady);
    end
    @(negedge clk);
    checks++;
    if (resValid !== 1'b1 || resS !== 16'h0300) begin
      errors++;
      $display("[TB] FAIL b2b_second: valid=%b s=%h required 1 0300", resValid, resS);
    end
    @(negedge clk);
    resReady = 1'b0;
    checks++;
    if (resValid !== 1'b0 || opCount !== 16'(base + 2)) begin
      errors++;
      $display("[TB] FAIL b2b_done: valid=%b cnt=%h required 0 %h", resValid, opCount, 16'(base + 2));
    end
  endtask

  initial begin
    rst = 1'b1;
    cmdValid = 1'b0; cmdA = '0; cmdB = '0; cmdM = 1'b0; resReady = 1'b0; clrSticky = 1'b0;
    cmdValid4 = 1'b0; cmdA4 = '0; cmdB4 = '0; cmdM4 = 1'b0; resReady4 = 1'b0;
    test_reset();
    test_add();
    test_backpressure();
    test_sticky();
    test_reset_mid_settle();
    test_count_wrap();
    test_clear_on_capture();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Registered command/result wrapper around the combinational 16-bit ALU (inputs A, B, M; outputs S, cout, N, Z, C, V).
- Accepts operations over a valid/ready command port and drives registered operands into the ALU.
- Waits a programmable settle time, then captures the ALU result and flags into output registers.
- Presents the captured result on a valid/ready result port.
- Maintains sticky carry/overflow flags and a completed-operation counter for the surrounding datapath.

Parameters:
- WIDTH, 16, data width of operands and result; must match the ALU.
- SETTLE_CYCLES, 1, clock edges between operand launch and result capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_m  input  1  mode: 0 = add, 1 = subtract.
- alu_a  output  WIDTH  registered operand A to ALU.
- alu_b  output  WIDTH  registered operand B to ALU.
- alu_m  output  1  registered mode to ALU.
- alu_s  input  WIDTH  ALU sum/difference.
- alu_cout  input  1  ALU carry out.
- alu_n, alu_z, alu_c, alu_v  input  1 each  ALU flags.
- res_valid  output  1  captured result available.
- res_ready  input  1  consumer accepts result.
- res_s  output  WIDTH  captured result.
- res_cout  output  1  captured carry out.
- res_flags  output  4  captured flags, packed {N,Z,C,V}.
- clr_sticky  input  1  synchronous clear of sticky flags.
- sticky_c  output  1  OR of C over captured ops since last clear.
- sticky_v  output  1  OR of V over captured ops since last clear.
- op_count  output  16  number of results consumed; wraps 0xFFFF to 0x0000.

Behaviour:

Reset (rst=1, asynchronous, any state):
- state = IDLE.
- cmd_ready=1, res_valid=0.
- alu_a=0, alu_b=0, alu_m=0.
- res_s=0, res_cout=0, res_flags=0.
- sticky_c=0, sticky_v=0, op_count=0, settle counter=0.
- Reset mid-operation abandons the operation; no partial result is ever presented.

State machine:

IDLE:
- cmd_ready=1, res_valid=0.
- On an edge with cmd_valid=1: register cmd_a/cmd_b/cmd_m into alu_a/alu_b/alu_m, load cnt=SETTLE_CYCLES-1, go to SETTLE.
- cmd_valid=0: hold all registers.

SETTLE:
- cmd_ready=0. cmd_* are ignored, and alu_* hold their values.
- Edge with cnt≠0: cnt decrements.
- Edge with cnt=0:
  - capture alu_s→res_s, alu_cout→res_cout, {alu_n,alu_z,alu_c,alu_v}→res_flags;
  - set res_valid=1; go to OUT.

OUT:
- cmd_ready=0; res_valid=1; res_* remain stable until the handshake.
- Edge with res_ready=1: res_valid←0, op_count←op_count+1, go to IDLE.
- res_ready=0: hold indefinitely (backpressure).
- res_* keep their last value after the handshake until the next capture.

Timing:
- Latency: command accepted at edge E0; res_valid is high after edge E0+SETTLE_CYCLES.
- Minimum issue interval: SETTLE_CYCLES+2 edges, including the result handshake edge and the IDLE accept edge. A command cannot be accepted on the same edge as the result handshake.

Sticky flags:
- On the capture edge, sticky_c ← sticky_c | alu_c and sticky_v ← sticky_v | alu_v.
- clr_sticky is honoured in any state. On a non-capture edge both sticky flags go to 0.
- If clr_sticky and capture coincide, the new value is exactly the captured flag; the prior sticky state is discarded.

Arithmetic:
- The block performs no arithmetic on data. Flags are passed through unchanged from the ALU.
- op_count is modulo 2^16.

Test Plan:
1. Reset, then cmd A=0x1234, B=0x4321, M=0 with SETTLE_CYCLES=1 -> res_valid high 1 edge after accept; res_s=0x5555, res_flags=0000, op_count=1 after res_ready.
2. A=0x1234, B=0x4321, M=1 -> res_s=0xCF13, N=1, Z=0, C=0, V=0; hold res_ready=0 for 5 cycles -> res_s and res_valid stable and cmd_ready=0 throughout.
3. A=0x7FFF, B=0x0001, M=0 -> res_s=0x8000, N=1, V=1; sticky_v=1. Then A=0x0001, B=0x0001, M=1 -> res_s=0x0000, Z=1, C=1; sticky_v remains 1 and sticky_c=1. Pulse clr_sticky -> both sticky flags 0.
4. Assert rst while in SETTLE (SETTLE_CYCLES=4, 2 edges after accept) -> all outputs go to reset values immediately; no res_valid pulse follows; the next command completes normally.
5. Preload op_count to 0xFFFF by issuing 65535 ops (or by force in simulation), then complete one op -> op_count=0x0000.
6. Drive clr_sticky on the capture edge of an op whose ALU gives V=1, with sticky_v previously 1 -> sticky_v=1. With V=0 on that edge -> sticky_v=0.
